fe_instr_buffer: RTL and testbench

- Fetch-side transmitter of the FE→ID interface. Accepts instruction-memory responses, buffers them in a small FIFO, and drives the registered FEID payload (info/instr/pred) that the ID stage aligner consumes.
- Honours the ID stall handshake and the MA-stage flush.
- Tracks outstanding bus requests so that responses in flight at a flush are discarded, never delivered.

---
 rtl/fe_instr_buffer.sv | 115 +++++++++++
 tb/tb_fe_instr_buffer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fe_instr_buffer.sv
// FE->ID transmitter: buffers instruction-memory responses in a small FIFO and
// drives the registered FEID payload, discarding responses orphaned by a flush.
module fe_instr_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic        s_stall_i,
  input  logic        s_req_issue_i,
  output logic        s_req_allow_o,
  input  logic        s_resp_valid_i,
  input  logic [31:0] s_resp_data_i,
  input  logic [1:0]  s_resp_err_i,
  input  logic [1:0]  s_resp_pred_i,
  input  logic        s_resp_hoff_i,
  output logic [4:0]  s_feid_info_o,
  output logic [31:0] s_feid_instr_o,
  output logic [1:0]  s_feid_pred_o,
  output logic        s_ovf_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
    logic [1:0]  pred;
    logic        hoff;
    logic        first;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   occ, outst, discard;
  logic            first_q;

  entry_t          resp_e, head_e;
  logic            accept, fifo_empty, fifo_full, pop, push_req, push, ovf_set;
  logic            disc_dec, outst_dec;
  logic [CW-1:0]   flush_disc;
  logic [CW+1:0]   allow_sum;

  always_comb begin
    resp_e     = '{data: s_resp_data_i, err: s_resp_err_i, pred: s_resp_pred_i,
                   hoff: s_resp_hoff_i, first: first_q};
    head_e     = mem[rd_ptr];
    accept     = s_resp_valid_i & (discard == '0) & ~s_flush_i;
    fifo_empty = (occ == '0);
    fifo_full  = (occ == CW'(DEPTH));
    pop        = ~s_flush_i & ~s_stall_i & ~fifo_empty;
    // Bypass only when nothing is queued ahead and ID can take it now.
    push_req   = accept & (s_stall_i | ~fifo_empty);
    push       = push_req & (~fifo_full | pop);
    ovf_set    = (push_req & fifo_full & ~pop) |
                 (s_resp_valid_i & (outst == '0) & (discard == '0));
    // Responses owed to the old stream drain discard before touching outstanding.
    disc_dec   = s_resp_valid_i & (discard != '0);
    outst_dec  = s_resp_valid_i & (discard == '0) & (outst != '0);
    flush_disc = outst + discard;
    if (s_resp_valid_i && flush_disc != '0) flush_disc = flush_disc - CW'(1);
    allow_sum     = (CW+2)'(occ) + (CW+2)'(outst) + (CW+2)'(discard);
    s_req_allow_o = (allow_sum < (CW+2)'(DEPTH));
  end

  always_ff @(posedge s_clk_i) begin
    if (push && !s_flush_i) mem[wr_ptr] <= resp_e;
  end

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      occ            <= '0;
      outst          <= '0;
      discard        <= '0;
      first_q        <= 1'b1;
      s_feid_info_o  <= '0;
      s_feid_instr_o <= '0;
      s_feid_pred_o  <= '0;
      s_ovf_o        <= 1'b0;
    end else begin
      s_ovf_o <= s_ovf_o | ovf_set;
      if (s_flush_i) begin
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        occ           <= '0;
        discard       <= flush_disc;
        outst         <= CW'(s_req_issue_i);
        first_q       <= 1'b1;
        s_feid_info_o <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        occ     <= occ + CW'(push) - CW'(pop);
        discard <= discard - CW'(disc_dec);
        outst   <= outst + CW'(s_req_issue_i) - CW'(outst_dec);
        if (accept) first_q <= 1'b0;
        if (!s_stall_i) begin
          if (pop) begin
            s_feid_info_o  <= {head_e.first, head_e.hoff, head_e.err, 1'b1};
            s_feid_instr_o <= head_e.data;
            s_feid_pred_o  <= head_e.pred;
          end else if (accept) begin
            s_feid_info_o  <= {resp_e.first, resp_e.hoff, resp_e.err, 1'b1};
            s_feid_instr_o <= resp_e.data;
            s_feid_pred_o  <= resp_e.pred;
          end else begin
            s_feid_info_o  <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fe_instr_buffer.sv
// Directed bench for fe_instr_buffer: bypass, stall buffering, flush discard,
// error/pred/hoff passthrough, overflow stickiness and reset.
module tb_fe_instr_buffer;
  logic        clk = 1'b0;
  logic        resetn, flush, stall, issue, allow;
  logic        rvalid, hoff, ovf;
  logic [31:0] rdata, instr;
  logic [1:0]  rerr, rpred, pred;
  logic [4:0]  info;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fe_instr_buffer #(.DEPTH(4)) dut (
    .s_clk_i(clk), .s_resetn_i(resetn), .s_flush_i(flush), .s_stall_i(stall),
    .s_req_issue_i(issue), .s_req_allow_o(allow),
    .s_resp_valid_i(rvalid), .s_resp_data_i(rdata), .s_resp_err_i(rerr),
    .s_resp_pred_i(rpred), .s_resp_hoff_i(hoff),
    .s_feid_info_o(info), .s_feid_instr_o(instr), .s_feid_pred_o(pred),
    .s_ovf_o(ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic resp(input logic [31:0] d, input logic [1:0] e, input logic [1:0] p, input logic h);
    rvalid = 1'b1; rdata = d; rerr = e; rpred = p; hoff = h;
    step();
    rvalid = 1'b0; rdata = '0; rerr = '0; rpred = '0; hoff = 1'b0;
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      issue = 1'b1;
      step();
    end
    issue = 1'b0;
  endtask

  logic [31:0] words [4];

  initial begin
    words[0] = 32'hA0A0_0001; words[1] = 32'hB0B0_0002;
    words[2] = 32'hC0C0_0003; words[3] = 32'hD0D0_0004;
    resetn = 1'b0; flush = 1'b0; stall = 1'b0; issue = 1'b0;
    rvalid = 1'b0; rdata = '0; rerr = '0; rpred = '0; hoff = 1'b0;
    step(); step();
    chk("rst_info", 32'(info), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    resetn = 1'b1;
    chk("rst_allow", 32'(allow), 32'h1);

    // single request, bypass delivery with first-flag set
    issue_n(1);
    chk("t1_allow_pend", 32'(allow), 32'h1);
    step();
    resp(32'h0000_0013, 2'b00, 2'b00, 1'b0);
    chk("t1_info", 32'(info), 32'h11);
    chk("t1_instr", instr, 32'h0000_0013);
    step();
    chk("t1_bubble", 32'(info), 32'h0);

    // buffer four words under stall, then drain
    stall = 1'b1;
    issue_n(4);
    chk("t2_allow_full_req", 32'(allow), 32'h0);
    for (int i = 0; i < 4; i++) resp(words[i], 2'b00, 2'b00, 1'b0);
    chk("t2_hold_info", 32'(info), 32'h0);
    chk("t2_allow_full_fifo", 32'(allow), 32'h0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_drain_info", 32'(info), 32'h01);
      chk("t2_drain_instr", instr, words[i]);
    end
    step();
    chk("t2_empty_info", 32'(info), 32'h0);
    chk("t2_ovf", 32'(ovf), 32'h0);

    // flush with in-flight responses, one response and one issue in the flush cycle
    issue_n(4);
    resp(32'hE0E0_0005, 2'b00, 2'b00, 1'b0);
    chk("t3_pre_info", 32'(info), 32'h01);
    stall = 1'b1; flush = 1'b1; issue = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    stall = 1'b0; flush = 1'b0; issue = 1'b0; rvalid = 1'b0; rdata = '0;
    chk("t3_flush_info", 32'(info), 32'h0);
    chk("t3_discard", 32'(dut.discard), 32'h2);
    chk("t3_outst", 32'(dut.outst), 32'h1);
    resp(32'hBAD0_0001, 2'b00, 2'b00, 1'b0);
    chk("t3_drop1", 32'(info), 32'h0);
    resp(32'hBAD0_0002, 2'b00, 2'b00, 1'b0);
    chk("t3_drop2", 32'(info), 32'h0);
    resp(32'hF0F0_0006, 2'b00, 2'b00, 1'b0);
    chk("t3_new_info", 32'(info), 32'h11);
    chk("t3_new_instr", instr, 32'hF0F0_0006);
    chk("t3_ovf", 32'(ovf), 32'h0);
    step();

    // error code, prediction and upper-halfword start pass through
    issue_n(1);
    resp(32'h1234_5678, 2'b10, 2'b01, 1'b1);
    chk("t4_info", 32'(info), 32'h0D);
    chk("t4_pred", 32'(pred), 32'h1);
    chk("t4_instr", instr, 32'h1234_5678);
    step();

    // overflow: fifth response into a full FIFO under stall
    stall = 1'b1;
    issue_n(4);
    for (int i = 0; i < 4; i++) resp(words[i], 2'b00, 2'b00, 1'b0);
    chk("t5_ovf_pre", 32'(ovf), 32'h0);
    resp(32'h5555_5555, 2'b00, 2'b00, 1'b0);
    chk("t5_ovf_set", 32'(ovf), 32'h1);
    stall = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t5_ovf_sticky", 32'(ovf), 32'h1);
    chk("t5_last_instr", instr, words[3]);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("t5_rst_ovf", 32'(ovf), 32'h0);
    chk("t5_rst_info", 32'(info), 32'h0);
    chk("t5_rst_instr", instr, 32'h0);
    chk("t5_rst_pred", 32'(pred), 32'h0);
    chk("t5_rst_allow", 32'(allow), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
